// File: rtl/cpu_press_gen.sv
// CPU player button generator for the tug-of-war game.
// Compares the pseudo-random value against the difficulty threshold while idle
// and issues a timed press followed by a cooldown gap.
// Optional press counter: define CPU_PRESS_CNT_EN to add the press_cnt output.
module cpu_press_gen #(
  parameter int unsigned RAND_W          = 10,
  parameter int unsigned PRESS_CYCLES    = 4,
  parameter int unsigned COOLDOWN_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [RAND_W-1:0] rand_in,
  input  logic [RAND_W-2:0] difficulty,
  output logic              press,
  output logic              press_pulse,
  output logic              busy
`ifdef CPU_PRESS_CNT_EN
  ,
  output logic [7:0]        press_cnt
`endif
);

  // Timer only needs to hold (max cycle count - 1).
  localparam int unsigned MaxCyc = (PRESS_CYCLES > COOLDOWN_CYCLES) ? PRESS_CYCLES
                                                                    : COOLDOWN_CYCLES;
  localparam int unsigned TimerW = (MaxCyc <= 1) ? 1 : $clog2(MaxCyc);

  localparam logic [TimerW-1:0] PressLoad    = TimerW'(PRESS_CYCLES - 1);
  localparam logic [TimerW-1:0] CooldownLoad = TimerW'(COOLDOWN_CYCLES - 1);

  if (PRESS_CYCLES < 1) begin : g_bad_press
    $error("PRESS_CYCLES must be >= 1");
  end
  if (COOLDOWN_CYCLES < 1) begin : g_bad_cooldown
    $error("COOLDOWN_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StPress, StCooldown} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              press_q, press_d;
  logic              pulse_q, pulse_d;
  logic              hit;

  // Unsigned compare against the zero-extended threshold; difficulty 0 never hits.
  assign hit = (rand_in < {1'b0, difficulty});

  // Next-state, timer and registered output values.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    press_d = 1'b0;
    pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (enable && hit) begin
          state_d = StPress;
          timer_d = PressLoad;
          press_d = 1'b1;
          pulse_d = 1'b1;
        end
      end
      StPress: begin
        // Disable wins over timer expiry.
        if (!enable) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TimerW'(1);
          press_d = 1'b1;
        end else begin
          state_d = StCooldown;
          timer_d = CooldownLoad;
        end
      end
      StCooldown: begin
        if (!enable) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TimerW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State, timer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      press_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      press_q <= press_d;
      pulse_q <= pulse_d;
    end
  end

  assign press       = press_q;
  assign press_pulse = pulse_q;
  assign busy        = (state_q != StIdle);

`ifdef CPU_PRESS_CNT_EN
  logic [7:0] cnt_q;

  // Saturating count of issued presses; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (pulse_d && (cnt_q != 8'hff)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign press_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_press_gen.sv
// Self-checking bench for cpu_press_gen: per-cycle reference model feeds an
// expected-output queue that is drained after each clock edge.
module tb_cpu_press_gen;

  localparam int P = 4;
  localparam int C = 8;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [9:0] rand_in;
  logic [8:0] difficulty;
  logic       press;
  logic       press_pulse;
  logic       busy;
`ifdef CPU_PRESS_CNT_EN
  logic [7:0] press_cnt;
`endif

  cpu_press_gen #(
    .RAND_W         (10),
    .PRESS_CYCLES   (P),
    .COOLDOWN_CYCLES(C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rand_in    (rand_in),
    .difficulty (difficulty),
    .press      (press),
    .press_pulse(press_pulse),
    .busy       (busy)
`ifdef CPU_PRESS_CNT_EN
    ,
    .press_cnt  (press_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       press;
    logic       pulse;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Model: position within a press/cooldown sequence, -1 when idle.
  int   m_pos = -1;
  int   m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic step(input string tag, input logic en, input logic [9:0] r,
                      input logic [8:0] d);
    exp_t e;
    exp_t g;
    enable     = en;
    rand_in    = r;
    difficulty = d;
    if (m_pos < 0) begin
      if (en && (r < {1'b0, d})) m_pos = 0;
    end else if (!en) begin
      m_pos = -1;
    end else if (m_pos == P + C - 1) begin
      m_pos = -1;
    end else begin
      m_pos++;
    end
    if (m_pos == 0 && m_cnt < 255) m_cnt++;
    e.press = (m_pos >= 0) && (m_pos < P);
    e.pulse = (m_pos == 0);
    e.busy  = (m_pos >= 0);
    e.cnt   = 8'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({tag, "_press"}, 32'(press), 32'(g.press));
    check({tag, "_pulse"}, 32'(press_pulse), 32'(g.pulse));
    check({tag, "_busy"}, 32'(busy), 32'(g.busy));
`ifdef CPU_PRESS_CNT_EN
    check({tag, "_cnt"}, 32'(press_cnt), 32'(g.cnt));
`endif
  endtask

  int pulses;
  int press_hi;
  int busy_lo;

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    rand_in    = 10'd0;
    difficulty = 9'd511;
    #1;
    check("rst_press", 32'(press), 32'd0);
    check("rst_pulse", 32'(press_pulse), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef CPU_PRESS_CNT_EN
    check("rst_cnt", 32'(press_cnt), 32'd0);
`endif
    #1;
    reset  = 1'b1;
    enable = 1'b1;

    // First press: pulse for one cycle, press for four.
    pulses = 0;
    press_hi = 0;
    for (int i = 0; i < 13; i++) begin
      step("first", 1'b1, 10'd0, 9'd511);
      if (press_pulse) pulses++;
      if (press) press_hi++;
    end
    check("first_pulses", 32'(pulses), 32'd1);
    check("first_press_cycles", 32'(press_hi), 32'd4);

    // Difficulty 0 never hits.
    pulses = 0;
    for (int i = 0; i < 1024; i++) begin
      step("dis", 1'b1, 10'(i), 9'd0);
      if (press || press_pulse) pulses++;
    end
    check("dis_any_press", 32'(pulses), 32'd0);

    // Hit boundary: equal is a miss, one below hits.
    for (int i = 0; i < 20; i++) step("bnd_eq", 1'b1, 10'd100, 9'd100);
    step("bnd_lt", 1'b1, 10'd99, 9'd100);
    check("bnd_lt_pulse_direct", 32'(press_pulse), 32'd1);
    for (int i = 0; i < 12; i++) step("bnd_tail", 1'b1, 10'd1023, 9'd100);

    // All-ones never hits even at max difficulty.
    for (int i = 0; i < 5; i++) step("ones", 1'b1, 10'd1023, 9'd511);

    // Continuous hit: period of 13.
    pulses = 0;
    press_hi = 0;
    busy_lo = 0;
    for (int i = 0; i < 39; i++) begin
      step("cont", 1'b1, 10'd0, 9'd511);
      if (press_pulse) pulses++;
      if (press) press_hi++;
      if (!busy) busy_lo++;
    end
    check("cont_pulses", 32'(pulses), 32'd3);
    check("cont_press", 32'(press_hi), 32'd12);
    check("cont_busy_lo", 32'(busy_lo), 32'd3);

    // Abort during the second press cycle.
    step("ab_idle", 1'b0, 10'd0, 9'd511);
    step("ab_p1", 1'b1, 10'd0, 9'd511);
    step("ab_p2", 1'b1, 10'd0, 9'd511);
    step("ab_off", 1'b0, 10'd0, 9'd511);
    check("ab_off_busy_direct", 32'(busy), 32'd0);
    step("ab_re", 1'b1, 10'd0, 9'd511);
    check("ab_re_pulse_direct", 32'(press_pulse), 32'd1);

    // Async reset mid-cooldown.
    for (int i = 0; i < 6; i++) step("cd", 1'b1, 10'd500, 9'd10);
    #2;
    reset = 1'b0;
    #1;
    m_pos = -1;
    m_cnt = 0;
    check("arst_press", 32'(press), 32'd0);
    check("arst_pulse", 32'(press_pulse), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
`ifdef CPU_PRESS_CNT_EN
    check("arst_cnt", 32'(press_cnt), 32'd0);
`endif
    #1;
    reset = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 15) != 0), 10'($urandom), 9'($urandom));
    end

`ifdef CPU_PRESS_CNT_EN
    // Enough presses to saturate the counter.
    for (int i = 0; i < 300 * (P + C + 1); i++) step("sat", 1'b1, 10'd0, 9'd511);
    check("sat_cnt_direct", 32'(press_cnt), 32'd255);
    step("sat_off", 1'b0, 10'd0, 9'd511);
    check("sat_cnt_kept", 32'(press_cnt), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_press_gen.md
Name: cpu_press_gen

Overview:
- Downstream consumer of the 10-bit pseudo-random generator in the tug-of-war vs CPU game.
- Each cycle in IDLE, compares the random value against a switch-set difficulty and, on a hit, issues a timed button press for the CPU player.
- Outputs drive the same tug-of-war playfield logic as a human button.
- A press/cooldown state machine spaces presses out, like a human press-and-release, so higher difficulty means more frequent presses.

Parameters:
- RAND_W, 10: width of rand_in.
- PRESS_CYCLES, 4: cycles press is held high per press; must be >= 1, elaboration error otherwise.
- COOLDOWN_CYCLES, 8: cycles press is held low after release before the next evaluation; must be >= 1, elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  game running; low freezes/aborts CPU activity.
- rand_in  input  RAND_W  current pseudo-random value, new value each cycle.
- difficulty  input  RAND_W-1  threshold from switches; 0 disables CPU.
- press  output  1  CPU button level, registered.
- press_pulse  output  1  one-cycle strobe on each new press, registered.
- busy  output  1  high when state is not IDLE.

Behaviour:
- States: IDLE, PRESS, COOLDOWN. Internal down-counter timer, width clog2(max(PRESS_CYCLES, COOLDOWN_CYCLES)), minimum 1.
- Reset low (async, no clock needed):
  - state=IDLE, timer=0, press=0, press_pulse=0, busy=0.
  - Release is sampled at the next rising edge.
- Hit condition: rand_in < zero-extended difficulty, unsigned compare, evaluated only in IDLE.
  - difficulty=0 never hits.
  - rand_in=all-ones never hits.
  - rand_in=0 hits for any difficulty >= 1.
- IDLE:
  - enable=1 and hit → at that edge: state=PRESS, timer=PRESS_CYCLES-1, press=1, press_pulse=1.
  - Otherwise remain in IDLE, outputs 0.
- PRESS:
  - press_pulse=0 after its first cycle.
  - timer≠0 → decrement.
  - timer==0 → state=COOLDOWN, timer=COOLDOWN_CYCLES-1, press=0.
  - press is high for exactly PRESS_CYCLES cycles.
- COOLDOWN:
  - timer≠0 → decrement.
  - timer==0 → state=IDLE.
  - The first evaluation occurs in the cycle after the transition edge.
- Timing:
  - Latency: hit sampled at edge N → press and press_pulse high after edge N.
  - Minimum pulse spacing: PRESS_CYCLES+COOLDOWN_CYCLES+1 cycles (default 13).
- enable=0 in PRESS or COOLDOWN: next edge forces state=IDLE, press=0, press_pulse=0, timer=0. enable=0 overrides timer expiry on the same edge.
- difficulty and rand_in changes outside IDLE are ignored.
- busy is combinational from state (state≠IDLE); no other combinational paths to outputs.

Optional Feature:
- Macro CPU_PRESS_CNT_EN.
- When defined:
  - Adds output press_cnt [7:0].
  - press_cnt increments on every edge that sets press_pulse=1, saturates at 255, and is cleared only by reset (to 0).
  - press_cnt is not cleared by enable=0.
- When undefined: the port and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset and first press: reset=0 with difficulty=511, rand_in=0 → press=0, busy=0 with no clock edge. Then reset=1, enable=1 → press_pulse=1 for exactly 1 cycle and press=1 for exactly 4 cycles, starting after the first edge.
- Disabled CPU: difficulty=0, rand_in swept 0..1023 over 1024 cycles, enable=1 → press and press_pulse never 1.
- Hit boundary: difficulty=100, rand_in=100 held 20 cycles → no press. Then rand_in=99 → press_pulse after next edge.
- Continuous hit: difficulty=511, rand_in=0 held, enable=1 for 40 cycles → press_pulse every 13 cycles, press high 4 of every 13, busy low 1 of every 13.
- Abort: enable→0 during the 2nd PRESS cycle → press=0, busy=0 after next edge. enable→1 with hit → new press_pulse after the following edge.
- Async reset mid-operation: reset→0 mid-COOLDOWN between edges → all outputs 0 immediately. With CPU_PRESS_CNT_EN: press_cnt=0 after reset, and 300 presses → press_cnt=255.
